// File: rtl/acc_result_fifo_if.sv
// ============================================================================
// Module   : acc_result_fifo_if
// Purpose  : Valid/ready stream carrying one accumulator result per transfer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface acc_result_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/acc_result_fifo.sv
// ============================================================================
// Module   : acc_result_fifo
// Purpose  : First-word-fall-through result FIFO behind the accumulator core.
//            Optional occupancy high-watermark under ACC_FIFO_WATERMARK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_result_fifo #(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    acc_result_fifo_if.slave      s_in,
    acc_result_fifo_if.master     m_out,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    input  wire logic             wm_clr,
    output logic [CNT_W-1:0]      high_wm
);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Status is decoded from the registered count only, so no input can
    // reach any output combinationally.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = s_in.valid & ~w_full;
    assign w_pop   = m_out.ready & ~w_empty;

    assign s_in.ready  = ~w_full;
    assign m_out.valid = ~w_empty;
    assign m_out.data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;

    // Storage holds no reset: contents are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_in.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifdef ACC_FIFO_WATERMARK_EN
    logic [CNT_W-1:0] r_high_wm;

    // Clear reloads with the present occupancy rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_wm <= '0;
        end else if (wm_clr) begin
            r_high_wm <= r_count;
        end else if (r_count > r_high_wm) begin
            r_high_wm <= r_count;
        end
    end

    assign high_wm = r_high_wm;
`else
    logic w_wm_clr_unused;

    assign w_wm_clr_unused = wm_clr;
    assign high_wm         = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_acc_result_fifo.sv
// ============================================================================
// Module   : tb_acc_result_fifo
// Purpose  : Directed vector bench for acc_result_fifo (DEPTH=4, 32-bit data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_result_fifo;

    localparam int DW = 32;
    localparam int CW = 3;

    typedef struct {
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        logic          clr;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_cnt;
        logic [CW-1:0] e_hwm;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          wm_clr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [CW-1:0] high_wm;

    int checks;
    int errors;

    vec_t vq[$];

    acc_result_fifo_if #(.DATA_WIDTH(DW)) u_in_if ();
    acc_result_fifo_if #(.DATA_WIDTH(DW)) u_out_if ();

    acc_result_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (4)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_in    (u_in_if),
        .m_out   (u_out_if),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .wm_clr  (wm_clr),
        .high_wm (high_wm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] din,
                                input logic ordy, input logic clr,
                                input logic e_ov, input logic [DW-1:0] e_od,
                                input int e_cnt, input int e_hwm);
        vec_t v;
        v.iv    = iv;
        v.din   = din;
        v.ordy  = ordy;
        v.clr   = clr;
        v.e_ov  = e_ov;
        v.e_od  = e_od;
        v.e_cnt = CW'(e_cnt);
        v.e_hwm = CW'(e_hwm);
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] din,
                         input logic ordy, input logic clr);
        @(negedge clk);
        u_in_if.valid  = iv;
        u_in_if.data   = din;
        u_out_if.ready = ordy;
        wm_clr         = clr;
        #1;
    endtask

    // Compares all outputs against a state described by occupancy/head/watermark.
    task automatic chk_state(input string tag, input logic e_ov, input logic [DW-1:0] e_od,
                             input logic [CW-1:0] e_cnt, input logic [CW-1:0] e_hwm_en);
        logic [CW-1:0] e_hwm;
`ifdef ACC_FIFO_WATERMARK_EN
        e_hwm = e_hwm_en;
`else
        e_hwm = '0;
`endif
        chk({tag, ".out_valid"}, DW'(u_out_if.valid), DW'(e_ov));
        chk({tag, ".out_data"},  u_out_if.data, e_od);
        chk({tag, ".count"},     DW'(count), DW'(e_cnt));
        chk({tag, ".full"},      DW'(full), DW'(e_cnt == 3'd4));
        chk({tag, ".empty"},     DW'(empty), DW'(e_cnt == 3'd0));
        chk({tag, ".in_ready"},  DW'(u_in_if.ready), DW'(e_cnt != 3'd4));
        chk({tag, ".high_wm"},   DW'(high_wm), DW'(e_hwm));
    endtask

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].iv, vq[i].din, vq[i].ordy, vq[i].clr);
            chk_state($sformatf("%s[%0d]", tag, i), vq[i].e_ov, vq[i].e_od,
                      vq[i].e_cnt, vq[i].e_hwm);
        end
        vq.delete();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        wm_clr         = 1'b0;
        u_in_if.valid  = 1'b0;
        u_in_if.data   = '0;
        u_out_if.ready = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk_state("reset", 1'b0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0);
        chk_state("idle", 1'b0, 0, 0, 0);

        // Fill to full, reject pushes while full, then drain in order
        vq.push_back(mk(1, 10, 0, 0, 0, 0,  0, 0));
        vq.push_back(mk(1, 20, 0, 0, 1, 10, 1, 0));
        vq.push_back(mk(1, 30, 0, 0, 1, 10, 2, 1));
        vq.push_back(mk(1, 40, 0, 0, 1, 10, 3, 2));
        vq.push_back(mk(1, 50, 0, 0, 1, 10, 4, 3));
        vq.push_back(mk(1, 60, 1, 0, 1, 10, 4, 4));
        vq.push_back(mk(0, 0,  1, 0, 1, 20, 3, 4));
        vq.push_back(mk(0, 0,  1, 0, 1, 30, 2, 4));
        vq.push_back(mk(0, 0,  1, 0, 1, 40, 1, 4));
        vq.push_back(mk(0, 0,  0, 0, 0, 0,  0, 4));
        run_vectors("fill");

        // Continuous push and pop
        for (int k = 1; k <= 100; k++) begin
            drive(1'b1, DW'(k), 1'b1, 1'b0);
            if (k == 1) chk_state($sformatf("stream[%0d]", k), 1'b0, 0, 0, 4);
            else        chk_state($sformatf("stream[%0d]", k), 1'b1, DW'(k - 1), 1, 4);
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        chk_state("stream_tail", 1'b1, 100, 1, 4);
        drive(1'b0, 0, 1'b0, 1'b0);
        chk_state("stream_end", 1'b0, 0, 0, 4);

        // Pointer wrap with single push/pop pairs
        for (int i = 0; i < 9; i++) begin
            vq.push_back(mk(1, DW'(32'hA0 + i), 0, 0, 0, 0, 0, 4));
            vq.push_back(mk(0, 0, 1, 0, 1, DW'(32'hA0 + i), 1, 4));
        end
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4));
        run_vectors("wrap");

        // Asynchronous reset while draining with count=3
        for (int i = 0; i < 4; i++) drive(1'b1, DW'(32'h11 + i), 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        chk_state("pre_rst4", 1'b1, 32'h11, 4, 4);
        drive(1'b0, 0, 1'b1, 1'b0);
        chk_state("pre_rst3", 1'b1, 32'h12, 3, 4);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 0, 0, 0);
        @(negedge clk);
        u_out_if.ready = 1'b0;
        rst_n          = 1'b1;

        // Post-reset push and watermark tracking / clear
        vq.push_back(mk(1, 32'h55, 0, 0, 0, 0,     0, 0));
        vq.push_back(mk(0, 0,      1, 0, 1, 32'h55, 1, 0));
        vq.push_back(mk(1, 32'hA1, 0, 0, 0, 0,     0, 1));
        vq.push_back(mk(1, 32'hA2, 0, 0, 1, 32'hA1, 1, 1));
        vq.push_back(mk(1, 32'hA3, 0, 0, 1, 32'hA1, 2, 1));
        vq.push_back(mk(0, 0,      1, 0, 1, 32'hA1, 3, 2));
        vq.push_back(mk(0, 0,      1, 0, 1, 32'hA2, 2, 3));
        vq.push_back(mk(0, 0,      1, 0, 1, 32'hA3, 1, 3));
        vq.push_back(mk(0, 0,      0, 0, 0, 0,     0, 3));
        vq.push_back(mk(1, 32'hB1, 0, 0, 0, 0,     0, 3));
        vq.push_back(mk(0, 0,      0, 1, 1, 32'hB1, 1, 3));
        vq.push_back(mk(0, 0,      0, 0, 1, 32'hB1, 1, 1));
        vq.push_back(mk(1, 32'hB2, 0, 0, 1, 32'hB1, 1, 1));
        vq.push_back(mk(0, 0,      0, 0, 1, 32'hB1, 2, 1));
        vq.push_back(mk(0, 0,      0, 0, 1, 32'hB1, 2, 2));
        run_vectors("wm");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
